// File: rtl/jedro_1_instr_queue.sv
// jedro_1_instr_queue
// Decode-side instruction queue between the fetch unit and the decoder.
// Buffers {instr, addr} pairs in a DEPTH-entry circular FIFO and presents the
// head entry to the decoder. The fetch-side ready depends only on occupancy
// (and reset), never on same-cycle fetch or decode inputs. A taken jump
// (flush_i) discards every buffered entry.
//
// Optional feature: define JEDRO_1_IQ_BYPASS_EN to let an empty queue forward
// the fetch pair straight to the decoder (0-cycle latency). With the macro
// undefined the queue always adds exactly one cycle of latency.

module jedro_1_instr_queue #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = 32'h00000013
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [DATA_WIDTH-1:0]         ifu_instr_i,
  input  logic [DATA_WIDTH-1:0]         ifu_addr_i,
  input  logic                          ifu_valid_i,
  output logic                          ifu_ready_o,
  output logic [DATA_WIDTH-1:0]         dec_instr_o,
  output logic [DATA_WIDTH-1:0]         dec_addr_o,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);

  // Storage: instruction and address kept side by side, indexed by pointer.
  logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] addr_mem_r  [DEPTH];

  // Circular pointers wrap naturally because DEPTH is a power of two.
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic empty_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic bypass_take_s;

  // Pointer increment helper; the modulo-DEPTH wrap comes from the width.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_ONE;
  endfunction

  assign empty_s = (count_r == CNT_EMPTY);
  assign full_s  = (count_r == CNT_FULL);

  // Ready comes from registered occupancy only; reset forces it low.
  assign ifu_ready_o = !rst_i && !full_s;

`ifdef JEDRO_1_IQ_BYPASS_EN
  // An empty queue hands the fetch pair directly to a ready decoder; that
  // pair is consumed in flight and never written into the array.
  assign bypass_take_s = empty_s && ifu_valid_i && dec_ready_i && !flush_i && !rst_i;
`else
  assign bypass_take_s = 1'b0;
`endif

  // A flush discards any same-cycle push or pop; the pop path only ever
  // drains stored entries, so a bypassed pair never moves rd_ptr.
  assign push_s = ifu_valid_i && ifu_ready_o && !flush_i && !bypass_take_s;
  assign pop_s  = !rst_i && !empty_s && dec_ready_i && !flush_i;

  // Decoder-side view: head entry, bypassed fetch pair, or NOP when idle.
  always_comb begin
    dec_valid_o = 1'b0;
    dec_instr_o = NOP_INSTR;
    dec_addr_o  = '0;
    if (rst_i) begin
      dec_valid_o = 1'b0;
      dec_instr_o = NOP_INSTR;
      dec_addr_o  = '0;
    end else if (!empty_s) begin
      dec_valid_o = 1'b1;
      dec_instr_o = instr_mem_r[rd_ptr_r];
      dec_addr_o  = addr_mem_r[rd_ptr_r];
`ifdef JEDRO_1_IQ_BYPASS_EN
    end else if (!flush_i) begin
      dec_valid_o = ifu_valid_i;
      dec_instr_o = ifu_instr_i;
      dec_addr_o  = ifu_addr_i;
`endif
    end else begin
      dec_valid_o = 1'b0;
      dec_instr_o = NOP_INSTR;
      dec_addr_o  = '0;
    end
  end

  // Occupancy reported to the outside reads zero for the whole reset pulse.
  always_comb begin
    if (rst_i) begin
      count_o = CNT_EMPTY;
    end else begin
      count_o = count_r;
    end
  end

  // Array write port; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= ifu_instr_i;
      addr_mem_r[wr_ptr_r]  <= ifu_addr_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush yields only to reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_EMPTY;
    end else if (flush_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= CNT_EMPTY;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/jedro_1_instr_queue.md
Name: jedro_1_instr_queue

Overview:
- Decode-side receiver of the fetch unit's instruction handshake (instr/addr/valid out, ready in).
- Buffers fetched instruction/address pairs in a small FIFO and presents them to the decoder.
- Drives the fetch-side ready from its own occupancy only, so fetch stalls depend on queue state and never on same-cycle fetch inputs.
- Flushes all buffered entries on a taken jump.

Parameters:
- DATA_WIDTH, 32, width of the instruction and of the address.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- NOP_INSTR, 32'h00000013, instruction word driven while the queue is empty (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all logic samples on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  taken jump; discards all entries; one-cycle pulse per jump.
- ifu_instr_i  in  DATA_WIDTH  instruction from fetch.
- ifu_addr_i  in  DATA_WIDTH  address of ifu_instr_i.
- ifu_valid_i  in  1  fetch presents a valid pair.
- ifu_ready_o  out  1  queue can accept a pair this cycle.
- dec_instr_o  out  DATA_WIDTH  head instruction to the decoder.
- dec_addr_o  out  DATA_WIDTH  head address.
- dec_valid_o  out  1  head entry valid.
- dec_ready_i  in  1  decoder consumes the head this cycle.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: DEPTH x {instr, addr} array, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, count of $clog2(DEPTH+1) bits.
- Reset (rst_i=1 at a clock edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Array contents are don't-care.
  - While rst_i is high: ifu_ready_o=0, dec_valid_o=0, dec_instr_o=NOP_INSTR, dec_addr_o=0, count_o=0.
  - Reset mid-operation drops all entries; the first cycle after deassertion has ifu_ready_o=1.
- ifu_ready_o = !rst_i && (count < DEPTH). It is purely registered-state derived, with no combinational path from ifu_valid_i, dec_ready_i or flush_i.
- Push = ifu_valid_i && ifu_ready_o && !flush_i. On push, write {ifu_instr_i, ifu_addr_i} at wr_ptr and increment wr_ptr.
- dec_valid_o = (count != 0). dec_instr_o/dec_addr_o = entry at rd_ptr when count != 0, otherwise NOP_INSTR/0.
- Pop = dec_valid_o && dec_ready_i && !flush_i. On pop, increment rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
- Latency: a push at edge N makes the entry visible on dec_* in the cycle after edge N (1 cycle, no bypass).
- Full (count=DEPTH): ifu_ready_o=0. A pop in the same cycle frees a slot only from the next cycle; there is no same-cycle refill.
- Empty (count=0): dec_valid_o=0; dec_ready_i is ignored.
- Push and pop together at any count in 1..DEPTH-1: count unchanged, both pointers advance.
- Pointer wrap: DEPTH-1 -> 0, with no bubble.
- flush_i=1 at an edge:
  - rd_ptr <= wr_ptr, count <= 0.
  - A push or pop in the same cycle is discarded.
  - The next cycle has dec_valid_o=0 and ifu_ready_o=1.
  - flush_i overrides everything except rst_i.
- Order is strict FIFO; no entry is duplicated or dropped except by flush or reset.

Optional Feature:
- Macro: JEDRO_1_IQ_BYPASS_EN.
- Defined: when count=0 and flush_i=0, the output side comes directly from the fetch side: dec_valid_o=ifu_valid_i, dec_instr_o=ifu_instr_i, dec_addr_o=ifu_addr_i.
  - If dec_ready_i=1 as well, the pair is consumed in the same cycle and not written; count stays 0 (0-cycle latency).
  - If dec_ready_i=0, the pair is pushed normally.
  - ifu_ready_o is unchanged and still independent of the inputs.
- Undefined: behaviour exactly as in Behaviour above, with 1-cycle latency and no combinational path from ifu_* to dec_*.

Test Plan:
- Reset then stream: rst_i high 2 cycles, then push 0x00100093@0x0, 0x00200113@0x4 with dec_ready_i=1 -> dec_valid_o rises 1 cycle after each push; decoder sees 0x00100093/0x0 then 0x00200113/0x4; count_o never exceeds 1.
- Fill to full: dec_ready_i=0, push 5 pairs at addr 0x0..0x10 -> ifu_ready_o=0 after the 4th accept, count_o=4, 5th pair held by fetch; raise dec_ready_i -> addrs 0x0,0x4,0x8,0xC out in order, then 0x10.
- Wrap: alternate push/pop for 10 cycles with count held at 2 -> pointers wrap twice; output addr sequence contiguous, no gap or duplicate.
- Flush with simultaneous push/pop: count=3, assert flush_i with ifu_valid_i=1 and dec_ready_i=1 -> next cycle count_o=0, dec_valid_o=0, dec_instr_o=NOP_INSTR; the flushed-cycle pair is never output.
- Reset mid-operation: count=2, rst_i high 1 cycle -> during reset ifu_ready_o=0, dec_valid_o=0; after reset count_o=0 and old entries never appear.
- Bypass (JEDRO_1_IQ_BYPASS_EN defined, queue empty): push 0x00000013@0x20 with dec_ready_i=1 -> dec_valid_o=1 and dec_addr_o=0x20 in the same cycle; count_o stays 0. With the macro undefined the same stimulus gives dec_valid_o=1 one cycle later.
